// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants, FSM state type and saturating-count helper for the hazard scheduler.
// The optional write-first bypass is selected by defining WB_BYPASS_EN.
package pipeline_hazard_ctrl_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_IDX_W  = 4;
  localparam int PEND_W     = 2;
  localparam int BR_TIMEOUT = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [0:0] {
    HZ_IDLE    = 1'b0,
    HZ_BR_WAIT = 1'b1
  } hz_state_e;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Per-register pending-write counters with one increment port, one decrement port,
// three read ports and an underflow indication.
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int SB_NUM_REGS  = NUM_REGS,
  parameter int SB_IDX_W     = REG_IDX_W,
  parameter int SB_PEND_W    = PEND_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_en,
  input  logic [SB_IDX_W-1:0]  inc_idx,
  input  logic                 dec_en,
  input  logic [SB_IDX_W-1:0]  dec_idx,
  input  logic [SB_IDX_W-1:0]  src1_idx,
  input  logic [SB_IDX_W-1:0]  src2_idx,
  input  logic [SB_IDX_W-1:0]  dest_idx,
  output logic [SB_PEND_W-1:0] src1_cnt,
  output logic [SB_PEND_W-1:0] src2_cnt,
  output logic [SB_PEND_W-1:0] dest_cnt,
  output logic                 underflow
);

  localparam logic [SB_PEND_W-1:0] PEND_ZERO = {SB_PEND_W{1'b0}};
  localparam logic [SB_PEND_W-1:0] PEND_ONE  = {{(SB_PEND_W-1){1'b0}}, 1'b1};
  localparam logic [SB_PEND_W-1:0] PEND_MAX  = {SB_PEND_W{1'b1}};

  logic [SB_PEND_W-1:0] pend_r [SB_NUM_REGS];
  logic                 same_reg_s;

  assign same_reg_s = inc_en && dec_en && (inc_idx == dec_idx);

  for (genvar i = 0; i < SB_NUM_REGS; i++) begin : g_pend
    logic inc_hit_s;
    logic dec_hit_s;

    assign inc_hit_s = inc_en && (inc_idx == SB_IDX_W'(i));
    assign dec_hit_s = dec_en && (dec_idx == SB_IDX_W'(i));

    // Pending counter: simultaneous issue and writeback on one register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_r[i] <= PEND_ZERO;
      end else begin
        case ({inc_hit_s, dec_hit_s})
          2'b10: begin
            if (pend_r[i] != PEND_MAX) begin
              pend_r[i] <= pend_r[i] + PEND_ONE;
            end else begin
              pend_r[i] <= pend_r[i];
            end
          end
          2'b01: begin
            if (pend_r[i] != PEND_ZERO) begin
              pend_r[i] <= pend_r[i] - PEND_ONE;
            end else begin
              pend_r[i] <= pend_r[i];
            end
          end
          default: pend_r[i] <= pend_r[i];
        endcase
      end
    end
  end

  assign src1_cnt  = pend_r[src1_idx];
  assign src2_cnt  = pend_r[src2_idx];
  assign dest_cnt  = pend_r[dest_idx];
  assign underflow = dec_en && (pend_r[dec_idx] == PEND_ZERO) && !same_reg_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard scheduler: RAW/WAW-capacity stall from the scoreboard, branch-wait FSM,
// stall performance counters and a sticky error flag. Optional macro: WB_BYPASS_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_src1_idx,
  input  logic                 dec_src1_used,
  input  logic [REG_IDX_W-1:0] dec_src2_idx,
  input  logic                 dec_src2_used,
  input  logic [REG_IDX_W-1:0] dec_dest_idx,
  input  logic                 dec_dest_write,
  input  logic                 dec_is_branch,
  input  logic                 branch_resolved,
  input  logic                 wb_enable,
  input  logic [REG_IDX_W-1:0] wb_reg_idx,
  output logic                 issue,
  output logic                 dep_stall,
  output logic                 branch_stall,
  output logic [CNT_W-1:0]     dep_stall_cycles,
  output logic [CNT_W-1:0]     br_stall_cycles,
  output logic                 error
);

  localparam int TMR_W = $clog2(BR_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BR_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_END  = TMR_W'(BR_TIMEOUT);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  hz_state_e         state_r;
  hz_state_e         state_nxt_s;
  logic [TMR_W-1:0]  timer_r;
  logic [TMR_W-1:0]  timer_nxt_s;
  logic              timeout_s;
  logic              ready_r;
  logic [CNT_W-1:0]  dep_cnt_r;
  logic [CNT_W-1:0]  br_cnt_r;
  logic              error_r;

  logic [PEND_W-1:0] src1_cnt_s;
  logic [PEND_W-1:0] src2_cnt_s;
  logic [PEND_W-1:0] dest_cnt_s;
  logic              underflow_s;
  logic              src1_fwd_s;
  logic              src2_fwd_s;
  logic              src1_busy_s;
  logic              src2_busy_s;
  logic              dest_full_s;
  logic              dep_s;
  logic              brs_s;
  logic              issue_s;

  pipeline_hazard_ctrl_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (issue_s && dec_dest_write),
    .inc_idx   (dec_dest_idx),
    .dec_en    (wb_enable),
    .dec_idx   (wb_reg_idx),
    .src1_idx  (dec_src1_idx),
    .src2_idx  (dec_src2_idx),
    .dest_idx  (dec_dest_idx),
    .src1_cnt  (src1_cnt_s),
    .src2_cnt  (src2_cnt_s),
    .dest_cnt  (dest_cnt_s),
    .underflow (underflow_s)
  );

`ifdef WB_BYPASS_EN
  // Write-first register file: the last outstanding write landing now satisfies the read.
  assign src1_fwd_s = wb_enable && (wb_reg_idx == dec_src1_idx) && (src1_cnt_s == PEND_ONE);
  assign src2_fwd_s = wb_enable && (wb_reg_idx == dec_src2_idx) && (src2_cnt_s == PEND_ONE);
`else
  assign src1_fwd_s = 1'b0;
  assign src2_fwd_s = 1'b0;
`endif

  assign src1_busy_s = dec_src1_used && (src1_cnt_s != PEND_ZERO) && !src1_fwd_s;
  assign src2_busy_s = dec_src2_used && (src2_cnt_s != PEND_ZERO) && !src2_fwd_s;
  assign dest_full_s = dec_dest_write && (dest_cnt_s == PEND_MAX);
  assign dep_s       = dec_valid && (src1_busy_s || src2_busy_s || dest_full_s);
  assign brs_s       = (state_r == HZ_BR_WAIT);
  // ready_r keeps issue low until the first clock edge after reset release.
  assign issue_s     = ready_r && lock && dec_valid && !dep_s && !brs_s;

  assign issue            = issue_s;
  assign dep_stall        = dep_s;
  assign branch_stall     = brs_s;
  assign dep_stall_cycles = dep_cnt_r;
  assign br_stall_cycles  = br_cnt_r;
  assign error            = error_r;

  // Branch-wait next state and timeout timer; everything holds while the PLL is unlocked.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    timeout_s   = 1'b0;
    case (state_r)
      HZ_IDLE: begin
        if (issue_s && dec_is_branch) begin
          state_nxt_s = HZ_BR_WAIT;
          timer_nxt_s = TMR_ZERO;
        end else begin
          state_nxt_s = HZ_IDLE;
        end
      end
      HZ_BR_WAIT: begin
        if (!lock) begin
          state_nxt_s = HZ_BR_WAIT;
        end else if (branch_resolved) begin
          state_nxt_s = HZ_IDLE;
          timer_nxt_s = TMR_ZERO;
        end else if (timer_r != TMR_END) begin
          timer_nxt_s = timer_r + TMR_ONE;
          timeout_s   = (timer_r == TMR_LAST);
        end else begin
          state_nxt_s = HZ_BR_WAIT;
        end
      end
      default: begin
        state_nxt_s = HZ_IDLE;
        timer_nxt_s = TMR_ZERO;
      end
    endcase
  end

  // FSM, timer and issue-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HZ_IDLE;
      timer_r <= TMR_ZERO;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      ready_r <= 1'b1;
    end
  end

  // Stall performance counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep_cnt_r <= {CNT_W{1'b0}};
      br_cnt_r  <= {CNT_W{1'b0}};
      error_r   <= 1'b0;
    end else begin
      if (lock && dep_s) begin
        dep_cnt_r <= sat_inc(dep_cnt_r);
      end else begin
        dep_cnt_r <= dep_cnt_r;
      end
      if (lock && brs_s) begin
        br_cnt_r <= sat_inc(br_cnt_r);
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      error_r <= error_r || underflow_s || timeout_s;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; expectations adapt to WB_BYPASS_EN.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 lock;
  logic                 dec_valid;
  logic [REG_IDX_W-1:0] dec_src1_idx;
  logic                 dec_src1_used;
  logic [REG_IDX_W-1:0] dec_src2_idx;
  logic                 dec_src2_used;
  logic [REG_IDX_W-1:0] dec_dest_idx;
  logic                 dec_dest_write;
  logic                 dec_is_branch;
  logic                 branch_resolved;
  logic                 wb_enable;
  logic [REG_IDX_W-1:0] wb_reg_idx;
  logic                 issue;
  logic                 dep_stall;
  logic                 branch_stall;
  logic [CNT_W-1:0]     dep_stall_cycles;
  logic [CNT_W-1:0]     br_stall_cycles;
  logic                 error;

  int checks = 0;
  int errors = 0;

`ifdef WB_BYPASS_EN
  localparam logic             A_WB_DEP = 1'b0;
  localparam logic [CNT_W-1:0] A_CNT    = 16'd2;
`else
  localparam logic             A_WB_DEP = 1'b1;
  localparam logic [CNT_W-1:0] A_CNT    = 16'd3;
`endif

  pipeline_hazard_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lock             (lock),
    .dec_valid        (dec_valid),
    .dec_src1_idx     (dec_src1_idx),
    .dec_src1_used    (dec_src1_used),
    .dec_src2_idx     (dec_src2_idx),
    .dec_src2_used    (dec_src2_used),
    .dec_dest_idx     (dec_dest_idx),
    .dec_dest_write   (dec_dest_write),
    .dec_is_branch    (dec_is_branch),
    .branch_resolved  (branch_resolved),
    .wb_enable        (wb_enable),
    .wb_reg_idx       (wb_reg_idx),
    .issue            (issue),
    .dep_stall        (dep_stall),
    .branch_stall     (branch_stall),
    .dep_stall_cycles (dep_stall_cycles),
    .br_stall_cycles  (br_stall_cycles),
    .error            (error)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] s1, input logic s1u,
                         input logic [3:0] s2, input logic s2u,
                         input logic [3:0] d, input logic dw, input logic br);
    dec_valid      = v;
    dec_src1_idx   = s1;
    dec_src1_used  = s1u;
    dec_src2_idx   = s2;
    dec_src2_used  = s2u;
    dec_dest_idx   = d;
    dec_dest_write = dw;
    dec_is_branch  = br;
  endtask

  task automatic wb(input logic en, input logic [3:0] idx);
    wb_enable  = en;
    wb_reg_idx = idx;
  endtask

  initial begin
    rst_n = 1'b0;
    lock = 1'b1;
    branch_resolved = 1'b0;
    wb(1'b0, 4'd0);
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    #12;
    chk_bit("rst_issue", issue, 1'b0);
    chk_bit("rst_dep", dep_stall, 1'b0);
    chk_bit("rst_brs", branch_stall, 1'b0);
    chk_bit("rst_error", error, 1'b0);
    chk_cnt("rst_depcnt", dep_stall_cycles, 16'd0);
    chk_cnt("rst_brcnt", br_stall_cycles, 16'd0);
    rst_n = 1'b1;
    tick();

    // RAW on R1 held until the cycle after its writeback
    settle();
    chk_bit("a_issue_w1", issue, 1'b1);
    tick();
    set_dec(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0);
    settle();
    chk_bit("a_dep0", dep_stall, 1'b1);
    chk_bit("a_noissue", issue, 1'b0);
    tick();
    settle();
    chk_bit("a_dep1", dep_stall, 1'b1);
    tick();
    wb(1'b1, 4'd1);
    settle();
    chk_bit("a_dep_wb", dep_stall, A_WB_DEP);
    tick();
    wb(1'b0, 4'd0);
    settle();
    chk_bit("a_dep_clear", dep_stall, 1'b0);
    chk_bit("a_issue", issue, 1'b1);
    chk_cnt("a_depcnt", dep_stall_cycles, A_CNT);

    // branch stall for four cycles until resolve
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    settle();
    chk_bit("b_issue_br", issue, 1'b1);
    chk_bit("b_brs_idle", branch_stall, 1'b0);
    tick();
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("b_brs0", branch_stall, 1'b1);
    chk_bit("b_noissue", issue, 1'b0);
    tick();
    tick();
    settle();
    chk_bit("b_brs2", branch_stall, 1'b1);
    tick();
    branch_resolved = 1'b1;
    settle();
    chk_bit("b_brs3", branch_stall, 1'b1);
    tick();
    branch_resolved = 1'b0;
    settle();
    chk_bit("b_idle", branch_stall, 1'b0);
    chk_bit("b_issue_after", issue, 1'b1);
    chk_cnt("b_brcnt", br_stall_cycles, 16'd4);

    // same-cycle issue and writeback on R2 leave pend[2] at 1
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    wb(1'b1, 4'd2);
    settle();
    chk_bit("c_issue_both", issue, 1'b1);
    tick();
    wb(1'b0, 4'd0);
    set_dec(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("c_dep_still1", dep_stall, 1'b1);
    tick();
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b1, 4'd2);
    tick();
    wb(1'b0, 4'd0);
    set_dec(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("c_dep_clear", dep_stall, 1'b0);
    tick();

    // WAW capacity: fourth write to R6 stalls
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    settle();
    chk_bit("d_full_dep", dep_stall, 1'b1);
    chk_bit("d_full_noissue", issue, 1'b0);
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b1, 4'd6);
    for (int i = 0; i < 3; i++) tick();
    wb(1'b0, 4'd0);
    set_dec(1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("d_drained", dep_stall, 1'b0);
    tick();

    // unlocked: no issue, FSM and counters hold, writeback still drains
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    tick();
    lock = 1'b0;
    set_dec(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    wb(1'b1, 4'd8);
    settle();
    chk_bit("f_nolock_issue", issue, 1'b0);
    tick();
    lock = 1'b1;
    wb(1'b0, 4'd0);
    set_dec(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("f_brs_hold", branch_stall, 1'b0);
    chk_bit("f_dep_drained", dep_stall, 1'b0);
    chk_cnt("f_depcnt_hold", dep_stall_cycles, A_CNT + 16'd1);
    tick();

    // branch timeout sets the sticky error while the stall is held
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    settle();
    chk_bit("h_err_before", error, 1'b0);
    tick();
    settle();
    chk_bit("h_err_timeout", error, 1'b1);
    chk_bit("h_brs_held", branch_stall, 1'b1);
    branch_resolved = 1'b1;
    tick();
    branch_resolved = 1'b0;
    settle();
    chk_bit("h_resolved", branch_stall, 1'b0);

    // reset in BR_WAIT with pend[3]=2
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    tick();
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    set_dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("g_brs_pre", branch_stall, 1'b1);
    chk_bit("g_dep_pre", dep_stall, 1'b1);
    rst_n = 1'b0;
    settle();
    chk_bit("g_brs_rst", branch_stall, 1'b0);
    chk_bit("g_dep_rst", dep_stall, 1'b0);
    chk_bit("g_issue_rst", issue, 1'b0);
    chk_bit("g_err_rst", error, 1'b0);
    chk_cnt("g_depcnt_rst", dep_stall_cycles, 16'd0);
    chk_cnt("g_brcnt_rst", br_stall_cycles, 16'd0);
    rst_n = 1'b1;
    tick();
    settle();
    chk_bit("g_dep_after", dep_stall, 1'b0);
    chk_bit("g_issue_after", issue, 1'b1);
    set_dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();

    // writeback to idle R7 underflows; error is sticky, counter stays 0
    wb(1'b1, 4'd7);
    tick();
    wb(1'b0, 4'd0);
    settle();
    chk_bit("e_err_set", error, 1'b1);
    tick();
    set_dec(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    settle();
    chk_bit("e_err_sticky", error, 1'b1);
    chk_bit("e_pend7_zero", dep_stall, 1'b0);
    tick();

`ifdef WB_BYPASS_EN
    // write-first bypass on R4
    set_dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b1, 4'd4);
    settle();
    chk_bit("byp_dep", dep_stall, 1'b0);
    chk_bit("byp_issue", issue, 1'b1);
    tick();
    wb(1'b0, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
